sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the async-style 'sram' model (active-low CE/OE/WE/LB/UB).
//  Grants the single SRAM to port 0 or port 1 by round-robin. Drives the SRAM strobes for the
//  model's multi-cycle access: a write needs 3 edges with WE low; read data appears on the 2nd edge.
//  Sits between the CPU memory stage (port 0) and the display/DMA fetcher (port 1).
// PARAMETERS
//  ADDR_W    16  address width, passed straight to sram addr
//  DATA_W    16  data width
//  WR_CYC     3  edges with CE/OE/WE low needed to commit a write; must match the SRAM model
//  RD_CYC     2  edges with CE/OE low before sram dout is valid; must match the SRAM model
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  reset      in   1       asynchronous, active-high reset
//  pN_req     in   1       N=0,1: request; held high with fields stable until pN_ack
//  pN_we      in   1       1=write, 0=read
//  pN_be      in   2       byte enables, active high: [0]=low byte, [1]=high byte
//  pN_addr    in   ADDR_W  word address
//  pN_wdata   in   DATA_W  write data
//  pN_ack     out  1       one-cycle completion pulse
//  pN_rdata   out  DATA_W  read data; valid while pN_ack=1 (driven from sram_dout)
//  sram_CE    out  1       chip enable, active low
//  sram_OE    out  1       output enable, active low (low for reads AND writes, per model)
//  sram_WE    out  1       write enable, active low
//  sram_LB    out  1       low-byte select, active low (= ~be[0] on writes, 0 on reads)
//  sram_UB    out  1       high-byte select, active low (= ~be[1] on writes, 0 on reads)
//  sram_addr  out  ADDR_W  registered address
//  sram_din   out  DATA_W  registered write data
//  sram_dout  in   DATA_W  SRAM read data
//  busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; sram_CE/OE/WE/LB/UB=1; sram_addr=0; sram_din=0; p0_ack=p1_ack=0;
//   cnt=0; last_gnt=1, so port 0 wins the first tie. Reset mid-access abandons it: no ack, and the
//   SRAM counters clear because CE is high.
//  All SRAM outputs and acks are registered. No combinational path from req to any output.
//  FSM: IDLE -> ACCESS -> RECOV -> IDLE.
//   IDLE:   at an edge where any req=1, pick a winner:
//           - one requester: it wins;
//           - both: the port != last_gnt wins.
//           At the same edge: last_gnt<=winner; latch addr, wdata, we and be of the winner into
//           sram_* regs; CE=0, OE=0, WE=~we; cnt<=0; go to ACCESS.
//   ACCESS: cnt increments each edge. Terminal edge is cnt==WR_CYC-1 (write) or cnt==RD_CYC-1
//           (read). At the terminal edge: CE=OE=WE=LB=UB<=1; winner's ack<=1; go to RECOV.
//   RECOV:  one cycle with CE high, so SRAM wcount/rcount are guaranteed 0. Ack<=0. Next IDLE.
//  Latency from the req-sampled edge to the ack-high cycle: write 3 cycles, read 2 cycles.
//   Full period is write 5 / read 4 cycles. The earliest next grant is the 2nd edge after ack.
//  pN_rdata = sram_dout for both ports. Valid only while the matching ack=1; sram_dout holds
//   afterwards but is not guaranteed.
//  A requester drops req or presents a new request in its ack cycle. IDLE samples req only after
//   RECOV, so a stale req is never re-granted.
//  be=00 on a write still runs a full write cycle and acks; the model ignores LB/UB.
//  Req changes during ACCESS/RECOV are ignored. The latched copy is used, and the losing port
//   simply waits.
//  Address/data are never wrapped or modified. The width is the SRAM's; the SRAM decodes only the
//   low 10 bits.
// TESTING
//  1 Reset: assert reset mid-write (cnt=1) -> all strobes 1, no ack, next access works normally.
//  2 p0 write addr=0x0005 data=0xBEEF be=11 -> CE/OE/WE low 3 edges; p0_ack 1 cycle; mem[5]=0xBEEF.
//  3 p1 read addr=0x0005 -> CE/OE low 2 edges, WE high; p1_ack with p1_rdata=0xBEEF.
//  4 p0,p1 req same edge, repeated 4 transactions -> grants p0,p1,p0,p1; no overlap; busy never
//    drops mid-access.
//  5 Back-to-back p0 writes 0x0000..0x0003 (req held, fields updated in ack cycle) -> ack every
//    5 cycles, readback matches.
//  6 p1 req held high during p0 ACCESS -> p1 granted at first IDLE edge after p0's RECOV.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
//   Bundles everything between the two requesters, the arbiter and the async
//   SRAM model.
//   Requester side (N = 0,1):
//     pN_req, pN_we, pN_be[1:0], pN_addr, pN_wdata   request fields
//     pN_ack, pN_rdata                               completion pulse and read data
//   SRAM side (strobes are active low):
//     sram_CE, sram_OE, sram_WE, sram_LB, sram_UB, sram_addr, sram_din
//     sram_dout                                      data coming back from the SRAM
//   busy                                             arbiter is not idle
//   Modports:
//     slave  - the arbiter's view
//     master - the environment's view (requesters plus SRAM)
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [1:0]        p0_be;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [1:0]        p1_be;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              sram_CE;
  logic              sram_OE;
  logic              sram_WE;
  logic              sram_LB;
  logic              sram_UB;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_be, p1_addr, p1_wdata,
    input  sram_dout,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output sram_CE, sram_OE, sram_WE, sram_LB, sram_UB, sram_addr, sram_din,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_be, p1_addr, p1_wdata,
    output sram_dout,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  sram_CE, sram_OE, sram_WE, sram_LB, sram_UB, sram_addr, sram_din,
    input  busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Round-robin arbiter and access sequencer sharing one async-style SRAM
//   between the CPU memory stage (port 0) and the display/DMA fetcher
//   (port 1). Each access is IDLE -> ACCESS -> RECOV -> IDLE: the strobes are
//   held low for WR_CYC edges on a write or RD_CYC edges on a read, then one
//   recovery cycle with CE high lets the SRAM's edge counters clear.
//   Ports:
//     clk    system clock, everything on posedge
//     reset  asynchronous, active-high; abandons any access in flight
//     bus    sram_arbiter_if.slave: both request ports, SRAM pins, busy
//   All SRAM pins and acks come straight from flops; pN_rdata is the SRAM
//   output passed through and is meaningful only while pN_ack is high.
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WR_CYC = 3,
  parameter int RD_CYC = 2
) (
  input logic         clk,
  input logic         reset,
  sram_arbiter_if.slave bus
);

  localparam int MAX_CYC = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RECOV  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_gnt_q, last_gnt_d;   // also the owner of the access in flight
  logic              wr_q, wr_d;
  logic              ce_q, ce_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic              lb_q, lb_d;
  logic              ub_q, ub_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;

  // Winner selection: a lone requester wins; on a tie the port that was not
  // served last wins.
  logic              win;
  logic              sel_we;
  logic [1:0]        sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign win       = (bus.p0_req && bus.p1_req) ? ~last_gnt_q : bus.p1_req;
  assign sel_we    = win ? bus.p1_we    : bus.p0_we;
  assign sel_be    = win ? bus.p1_be    : bus.p0_be;
  assign sel_addr  = win ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;

  // NOTE: every always_comb target gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    wr_d       = wr_q;
    ce_d       = ce_q;
    oe_d       = oe_q;
    we_d       = we_q;
    lb_d       = lb_q;
    ub_d       = ub_q;
    addr_d     = addr_q;
    din_d      = din_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          last_gnt_d = win;
          wr_d       = sel_we;
          addr_d     = sel_addr;
          din_d      = sel_wdata;
          ce_d       = 1'b0;
          oe_d       = 1'b0;        // the SRAM model wants OE low for writes too
          we_d       = ~sel_we;
          // Byte lanes only matter on writes; reads always fetch the full word.
          lb_d       = sel_we ? ~sel_be[0] : 1'b0;
          ub_d       = sel_we ? ~sel_be[1] : 1'b0;
          cnt_d      = '0;
          state_d    = ACCESS;
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if ((wr_q && cnt_q == WR_LAST) || (!wr_q && cnt_q == RD_LAST)) begin
          ce_d = 1'b1;
          oe_d = 1'b1;
          we_d = 1'b1;
          lb_d = 1'b1;
          ub_d = 1'b1;
          if (last_gnt_q) ack1_d = 1'b1;
          else            ack0_d = 1'b1;
          state_d = RECOV;
        end
      end

      // CE is already high here; this cycle lets the SRAM counters reach zero
      // and keeps the just-acked requester from being re-granted on stale req.
      RECOV: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;           // port 0 wins the first tie
      wr_q       <= 1'b0;
      ce_q       <= 1'b1;
      oe_q       <= 1'b1;
      we_q       <= 1'b1;
      lb_q       <= 1'b1;
      ub_q       <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      wr_q       <= wr_d;
      ce_q       <= ce_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      lb_q       <= lb_d;
      ub_q       <= ub_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  assign bus.sram_CE   = ce_q;
  assign bus.sram_OE   = oe_q;
  assign bus.sram_WE   = we_q;
  assign bus.sram_LB   = lb_q;
  assign bus.sram_UB   = ub_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_din  = din_q;
  assign bus.p0_ack    = ack0_q;
  assign bus.p1_ack    = ack1_q;
  assign bus.p0_rdata  = bus.sram_dout;
  assign bus.p1_rdata  = bus.sram_dout;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//   Directed bench for sram_arbiter. Contains a behavioural model of the
//   async SRAM (write commits on the 3rd edge with CE/WE low, read data on the
//   2nd edge with CE low, LB/UB ignored, low 10 address bits decoded).
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  logic clk;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;

  sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WR_CYC(3), .RD_CYC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- SRAM model ----------------
  logic [15:0] mem [0:1023];
  int          wcount = 0;
  int          rcount = 0;

  always @(posedge clk) begin
    if (bus.sram_CE) begin
      wcount <= 0;
      rcount <= 0;
    end else if (!bus.sram_WE) begin
      wcount <= wcount + 1;
      if (wcount == 2) mem[bus.sram_addr[9:0]] <= bus.sram_din;
    end else if (!bus.sram_OE) begin
      rcount <= rcount + 1;
      if (rcount == 1) bus.sram_dout <= mem[bus.sram_addr[9:0]];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit port, input bit req, input bit we, input logic [1:0] be,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (!port) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_be = be; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_be = be; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  // Issues one request and waits for its ack. cyc = falling edges from the
  // request to the ack cycle (-1 on timeout); ce_n/we_n = falling edges with
  // that strobe low; lbub = {UB,LB} at the first CE-low sample.
  task automatic xfer(input bit port, input bit we, input logic [1:0] be,
                      input logic [15:0] addr, input logic [15:0] wdata,
                      output int cyc, output logic [15:0] rdata,
                      output int ce_n, output int we_n, output logic [1:0] lbub);
    bit got;
    got = 1'b0; cyc = 0; ce_n = 0; we_n = 0; lbub = 2'bxx; rdata = 'x;
    drive(port, 1'b1, we, be, addr, wdata);
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!bus.sram_CE) begin
        ce_n++;
        if (ce_n == 1) lbub = {bus.sram_UB, bus.sram_LB};
      end
      if (!bus.sram_WE) we_n++;
      if (port ? bus.p1_ack : bus.p0_ack) begin
        got   = 1'b1;
        rdata = port ? bus.p1_rdata : bus.p0_rdata;
      end
    end
    if (!got) cyc = -1;
    if (!port) bus.p0_req = 1'b0;
    else       bus.p1_req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int cyc, ce_n, we_n, acks;
    logic [15:0] rd;
    logic [1:0] lbub;
    @(negedge clk);
    vectors++;
    if ({bus.sram_CE, bus.sram_OE, bus.sram_WE, bus.sram_LB, bus.sram_UB} !== 5'b11111) begin
      miscompares++;
      $display("FAIL reset_strobes got %b want 11111",
               {bus.sram_CE, bus.sram_OE, bus.sram_WE, bus.sram_LB, bus.sram_UB});
    end
    vectors++;
    if ({bus.sram_addr, bus.sram_din} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_addr_din got %h want 00000000", {bus.sram_addr, bus.sram_din});
    end
    vectors++;
    if ({bus.p0_ack, bus.p1_ack, bus.busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ack_busy got %b want 000", {bus.p0_ack, bus.p1_ack, bus.busy});
    end

    // Start a p0 write, then reset it after the cnt=1 edge.
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 2'b11, 16'h0030, 16'hDEAD);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.sram_CE, bus.sram_OE, bus.sram_WE, bus.sram_LB, bus.sram_UB, bus.busy, bus.p0_ack}
        !== 7'b1111100) begin
      miscompares++;
      $display("FAIL midwrite_reset got %b want 1111100",
               {bus.sram_CE, bus.sram_OE, bus.sram_WE, bus.sram_LB, bus.sram_UB, bus.busy, bus.p0_ack});
    end
    bus.p0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.p0_ack || bus.p1_ack) acks++;
    end
    vectors++;
    if (acks !== 0) begin
      miscompares++;
      $display("FAIL abandoned_ack got %0d acks want 0", acks);
    end

    xfer(1'b0, 1'b1, 2'b11, 16'h0030, 16'h1234, cyc, rd, ce_n, we_n, lbub);
    vectors++;
    if (cyc !== 4 || ce_n !== 3 || we_n !== 3) begin
      miscompares++;
      $display("FAIL post_reset_write got cyc=%0d ce=%0d we=%0d want cyc=4 ce=3 we=3", cyc, ce_n, we_n);
    end
    @(negedge clk);
    vectors++;
    if (mem[10'h030] !== 16'h1234) begin
      miscompares++;
      $display("FAIL post_reset_mem got %h want 1234", mem[10'h030]);
    end
  endtask

  task automatic test_write();
    int cyc, ce_n, we_n;
    logic [15:0] rd;
    logic [1:0] lbub;
    repeat (2) @(negedge clk);
    xfer(1'b0, 1'b1, 2'b11, 16'h0005, 16'hBEEF, cyc, rd, ce_n, we_n, lbub);
    vectors++;
    if (cyc !== 4 || ce_n !== 3 || we_n !== 3 || lbub !== 2'b00) begin
      miscompares++;
      $display("FAIL p0_write got cyc=%0d ce=%0d we=%0d ublb=%b want 4 3 3 00", cyc, ce_n, we_n, lbub);
    end
    @(negedge clk);
    vectors++;
    if (bus.p0_ack !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_one_cycle got ack=%b busy=%b want 0 0", bus.p0_ack, bus.busy);
    end
    vectors++;
    if (mem[10'h005] !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL mem5 got %h want beef", mem[10'h005]);
    end

    // Byte-enable corners: be=00 still runs a full write; be=01 drives only LB.
    xfer(1'b0, 1'b1, 2'b00, 16'h0006, 16'h5A5A, cyc, rd, ce_n, we_n, lbub);
    vectors++;
    if (cyc !== 4 || lbub !== 2'b11) begin
      miscompares++;
      $display("FAIL be00_write got cyc=%0d ublb=%b want 4 11", cyc, lbub);
    end
    repeat (2) @(negedge clk);
    xfer(1'b0, 1'b1, 2'b01, 16'h0007, 16'h0077, cyc, rd, ce_n, we_n, lbub);
    vectors++;
    if (cyc !== 4 || lbub !== 2'b10) begin
      miscompares++;
      $display("FAIL be01_write got cyc=%0d ublb=%b want 4 10", cyc, lbub);
    end
  endtask

  task automatic test_read();
    int cyc, ce_n, we_n;
    logic [15:0] rd;
    logic [1:0] lbub;
    repeat (2) @(negedge clk);
    xfer(1'b1, 1'b0, 2'b00, 16'h0005, 16'h0000, cyc, rd, ce_n, we_n, lbub);
    vectors++;
    if (cyc !== 3 || ce_n !== 2 || we_n !== 0 || lbub !== 2'b00) begin
      miscompares++;
      $display("FAIL p1_read got cyc=%0d ce=%0d we=%0d ublb=%b want 3 2 0 00", cyc, ce_n, we_n, lbub);
    end
    vectors++;
    if (rd !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL p1_rdata got %h want beef", rd);
    end
  endtask

  task automatic test_round_robin();
    bit order [4];
    int idx, n0, n1, cyc, bad;
    logic [15:0] p1_rd;
    repeat (2) @(negedge clk);
    idx = 0; n0 = 0; n1 = 0; cyc = 0; bad = 0; p1_rd = 'x;
    drive(1'b0, 1'b1, 1'b1, 2'b11, 16'h0010, 16'h1111);
    drive(1'b1, 1'b1, 1'b1, 2'b11, 16'h0020, 16'h3333);
    while (idx < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.p0_ack && bus.p1_ack) bad++;
      if (!bus.sram_CE && !bus.busy) bad++;
      if (bus.p0_ack) begin
        if (idx < 4) order[idx] = 1'b0;
        idx++; n0++;
        if (n0 == 1) drive(1'b0, 1'b1, 1'b1, 2'b11, 16'h0011, 16'h2222);
        else         bus.p0_req = 1'b0;
      end
      if (bus.p1_ack) begin
        if (idx < 4) order[idx] = 1'b1;
        idx++; n1++;
        if (n1 == 1) drive(1'b1, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
        else begin
          p1_rd = bus.p1_rdata;
          bus.p1_req = 1'b0;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (order[i] !== i[0]) begin
        miscompares++;
        $display("FAIL rr_grant%0d got port %0d want port %0d", i, order[i], i[0]);
      end
    end
    vectors++;
    if (cyc !== 18) begin
      miscompares++;
      $display("FAIL rr_total_cycles got %0d want 18", cyc);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL rr_overlap_busy got %0d violations want 0", bad);
    end
    vectors++;
    if (p1_rd !== 16'h1111) begin
      miscompares++;
      $display("FAIL rr_readback got %h want 1111", p1_rd);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, ce_n, we_n;
    logic [15:0] rd;
    logic [1:0] lbub;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 1'b1, 2'b11, 16'(i), 16'hA000 + 16'(i), cyc, rd, ce_n, we_n, lbub);
      vectors++;
      if (cyc !== ((i == 0) ? 4 : 5)) begin
        miscompares++;
        $display("FAIL b2b_write%0d got %0d cycles want %0d", i, cyc, (i == 0) ? 4 : 5);
      end
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 1'b0, 2'b00, 16'(i), 16'h0000, cyc, rd, ce_n, we_n, lbub);
      vectors++;
      if (rd !== 16'hA000 + 16'(i) || cyc !== ((i == 0) ? 3 : 4)) begin
        miscompares++;
        $display("FAIL b2b_read%0d got data=%h cyc=%0d want data=%h cyc=%0d",
                 i, rd, cyc, 16'hA000 + 16'(i), (i == 0) ? 3 : 4);
      end
    end
  endtask

  task automatic test_wait_during_access();
    int cyc, p0_at, p1_at;
    logic [15:0] rd;
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'b11, 16'h0040, 16'h4444);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 16'h0005, 16'h0000);
    cyc = 0; p0_at = -1; p1_at = -1; rd = 'x;
    while (p1_at < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.p0_ack) begin
        p0_at = cyc;
        bus.p0_req = 1'b0;
      end
      if (bus.p1_ack) begin
        p1_at = cyc;
        rd = bus.p1_rdata;
        bus.p1_req = 1'b0;
      end
    end
    vectors++;
    if (p0_at !== 3 || p1_at !== 7) begin
      miscompares++;
      $display("FAIL held_req_timing got p0_ack@%0d p1_ack@%0d want 3 7", p0_at, p1_at);
    end
    vectors++;
    if (rd !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL held_req_rdata got %h want beef", rd);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_back_to_back();
    test_wait_during_access();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
